// File: rtl/multi_priority_allocator.sv
// Busy-bitmap entry allocator: grants up to NUM_ALLOC lowest-index free entries per
// cycle, retires entries through a qualified free mask, and clears everything on flush.
module multi_priority_allocator #(
   parameter int DEPTH     = 8,
   parameter int NUM_ALLOC = 2,
   localparam int IDX_W    = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_ALLOC-1:0]       alloc_req,
   output logic [NUM_ALLOC-1:0]       alloc_gnt,
   output logic [NUM_ALLOC*IDX_W-1:0] alloc_idx,
   input  logic                       free_valid,
   input  logic [DEPTH-1:0]           free_mask,
   input  logic                       flush,
   output logic [DEPTH-1:0]           busy,
   output logic [IDX_W:0]             free_count,
   output logic                       full,
   output logic                       empty
);

   localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

   logic [DEPTH-1:0]           r_busy;
   logic [IDX_W:0]             r_free_count;
   logic                       r_full;
   logic                       r_empty;

   logic [DEPTH-1:0]           w_avail;
   logic [IDX_W-1:0]           w_sel;
   logic                       w_hit;
   logic [NUM_ALLOC-1:0]       w_gnt;
   logic [NUM_ALLOC*IDX_W-1:0] w_idx;
   logic [DEPTH-1:0]           w_grant_oh;
   logic [DEPTH-1:0]           w_busy_next;
   logic [IDX_W:0]             w_free_next;

   // Stage k finds the lowest free entry left after stages 0..k-1 masked theirs out,
   // so slot k always maps to the k-th free entry regardless of lower-slot requests.
   always_comb begin
      w_avail    = ~r_busy;
      w_sel      = '0;
      w_hit      = 1'b0;
      w_gnt      = '0;
      w_idx      = '0;
      w_grant_oh = '0;
      for (int k = 0; k < NUM_ALLOC; k++) begin
         w_sel = '0;
         w_hit = 1'b0;
         for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_avail[i]) begin
               w_hit = 1'b1;
               w_sel = IDX_W'(i);
            end
         end
         if (w_hit) begin
            w_avail[w_sel]             = 1'b0;
            w_idx[k*IDX_W +: IDX_W]    = w_sel;
            if (alloc_req[k] && !flush) begin
               w_gnt[k]          = 1'b1;
               w_grant_oh[w_sel] = 1'b1;
            end
         end
      end
   end

   // Grants only hit entries free in r_busy, so they never collide with this cycle's frees.
   always_comb begin
      w_busy_next = flush ? '0 : ((r_busy & ~(free_valid ? free_mask : '0)) | w_grant_oh);
      w_free_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!w_busy_next[i]) w_free_next = w_free_next + (IDX_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy       <= '0;
         r_free_count <= DEPTH_CNT;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
      end else begin
         r_busy       <= w_busy_next;
         r_free_count <= w_free_next;
         r_full       <= (w_free_next == '0);
         r_empty      <= (w_free_next == DEPTH_CNT);
      end
   end

   assign alloc_gnt  = w_gnt;
   assign alloc_idx  = w_idx;
   assign busy       = r_busy;
   assign free_count = r_free_count;
   assign full       = r_full;
   assign empty      = r_empty;

endmodule

// File: tb/tb_multi_priority_allocator.sv
// Bench for multi_priority_allocator (DEPTH=8, NUM_ALLOC=2): free-list model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_multi_priority_allocator;

   localparam int DEPTH = 8;
   localparam int NA    = 2;
   localparam int IW    = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [NA-1:0]   alloc_req = '0;
   logic [NA-1:0]   alloc_gnt;
   logic [NA*IW-1:0] alloc_idx;
   logic            free_valid = 1'b0;
   logic [DEPTH-1:0] free_mask = '0;
   logic            flush = 1'b0;
   logic [DEPTH-1:0] busy;
   logic [IW:0]     free_count;
   logic            full;
   logic            empty;

   int   checks = 0;
   int   errors = 0;
   logic check_en = 1'b0;
   logic [DEPTH-1:0] m_busy = '0;

   multi_priority_allocator #(.DEPTH(DEPTH), .NUM_ALLOC(NA)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_req  (alloc_req),
      .alloc_gnt  (alloc_gnt),
      .alloc_idx  (alloc_idx),
      .free_valid (free_valid),
      .free_mask  (free_mask),
      .flush      (flush),
      .busy       (busy),
      .free_count (free_count),
      .full       (full),
      .empty      (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: entry k of the ascending free list is what slot k may receive.
   task automatic model_step();
      int fq[$];
      logic [DEPTH-1:0] nb;
      if (flush) begin
         m_busy = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) fq.push_back(i);
         nb = m_busy & ~(free_valid ? free_mask : '0);
         for (int k = 0; k < NA; k++) if (alloc_req[k] && k < fq.size()) nb[fq[k]] = 1'b1;
         m_busy = nb;
      end
   endtask

   always @(negedge clk) begin : cmp
      int fq[$];
      logic egnt;
      if (rst_n && check_en) begin
         fq = {};
         for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) fq.push_back(i);
         chk("busy", 32'(busy), 32'(m_busy));
         chk("free_count", 32'(free_count), 32'(fq.size()));
         chk("full", 32'(full), 32'(fq.size() == 0));
         chk("empty", 32'(empty), 32'(fq.size() == DEPTH));
         for (int k = 0; k < NA; k++) begin
            egnt = alloc_req[k] && !flush && (k < fq.size());
            chk($sformatf("gnt%0d", k), 32'(alloc_gnt[k]), 32'(egnt));
            if (egnt) chk($sformatf("idx%0d", k), 32'(alloc_idx[k*IW +: IW]), 32'(fq[k]));
         end
      end
   end

   task automatic drive(input logic [1:0] req, input logic fv, input logic [7:0] fm, input logic fl);
      alloc_req  = req;
      free_valid = fv;
      free_mask  = fm;
      flush      = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_busy(input logic [7:0] b);
      drive(2'b00, 1'b0, 8'h00, 1'b1);
      tick();
      repeat (4) begin
         drive(2'b11, 1'b0, 8'h00, 1'b0);
         tick();
      end
      drive(2'b00, 1'b1, ~b, 1'b0);
      tick();
      drive(2'b00, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      // 1. Reset
      #1 rst_n = 1'b0;
      drive(2'b11, 1'b0, 8'h00, 1'b0);
      #1;
      chk("rst_busy", 32'(busy), 32'h00);
      chk("rst_free_count", 32'(free_count), 32'd8);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_gnt", 32'(alloc_gnt), 32'b11);
      chk("rst_idx0", 32'(alloc_idx[0 +: IW]), 32'd0);
      chk("rst_idx1", 32'(alloc_idx[IW +: IW]), 32'd1);
      @(negedge clk);
      rst_n    = 1'b1;
      check_en = 1'b1;
      m_busy   = '0;
      tick();
      chk("rel_busy", 32'(busy), 32'h03);
      chk("rel_free_count", 32'(free_count), 32'd6);
      chk("rel_empty", 32'(empty), 32'd0);

      // 2. Fill
      for (int k = 1; k < 4; k++) begin
         drive(2'b11, 1'b0, 8'h00, 1'b0);
         chk("fill_gnt", 32'(alloc_gnt), 32'b11);
         chk("fill_idx0", 32'(alloc_idx[0 +: IW]), 32'(2*k));
         chk("fill_idx1", 32'(alloc_idx[IW +: IW]), 32'(2*k+1));
         tick();
      end
      chk("fill_busy", 32'(busy), 32'hFF);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_free_count", 32'(free_count), 32'd0);
      drive(2'b11, 1'b0, 8'h00, 1'b0);
      chk("full_gnt", 32'(alloc_gnt), 32'b00);
      tick();
      chk("full_busy", 32'(busy), 32'hFF);

      // 3. Holes / partial grant
      drive(2'b00, 1'b1, 8'b0010_0100, 1'b0);
      tick();
      chk("hole_busy", 32'(busy), 32'hDB);
      chk("hole_free_count", 32'(free_count), 32'd2);
      drive(2'b11, 1'b0, 8'h00, 1'b0);
      chk("hole_idx0", 32'(alloc_idx[0 +: IW]), 32'd2);
      chk("hole_idx1", 32'(alloc_idx[IW +: IW]), 32'd5);
      drive(2'b10, 1'b0, 8'h00, 1'b0);
      chk("hole_gnt_hi", 32'(alloc_gnt), 32'b10);
      chk("hole_idx1_only", 32'(alloc_idx[IW +: IW]), 32'd5);
      tick();
      chk("hole_busy_fb", 32'(busy), 32'hFB);
      drive(2'b11, 1'b0, 8'h00, 1'b0);
      chk("one_free_gnt", 32'(alloc_gnt), 32'b01);
      chk("one_free_idx0", 32'(alloc_idx[0 +: IW]), 32'd2);
      tick();
      chk("one_free_busy", 32'(busy), 32'hFF);
      chk("one_free_full", 32'(full), 32'd1);

      // 4. Simultaneous free + alloc
      set_busy(8'hFE);
      chk("sim_pre_busy", 32'(busy), 32'hFE);
      drive(2'b11, 1'b1, 8'h02, 1'b0);
      chk("sim_gnt", 32'(alloc_gnt), 32'b01);
      chk("sim_idx0", 32'(alloc_idx[0 +: IW]), 32'd0);
      tick();
      chk("sim_busy", 32'(busy), 32'hFD);
      chk("sim_free_count", 32'(free_count), 32'd1);

      // 5. Flush priority
      set_busy(8'h3C);
      chk("fl_pre_busy", 32'(busy), 32'h3C);
      drive(2'b11, 1'b1, 8'hFF, 1'b1);
      chk("fl_gnt", 32'(alloc_gnt), 32'b00);
      tick();
      chk("fl_busy", 32'(busy), 32'h00);
      chk("fl_free_count", 32'(free_count), 32'd8);
      chk("fl_empty", 32'(empty), 32'd1);

      // 6. Async reset mid-run, then a redundant free
      set_busy(8'hA5);
      chk("ar_pre_busy", 32'(busy), 32'hA5);
      chk("ar_pre_free_count", 32'(free_count), 32'd4);
      #1 rst_n = 1'b0;
      m_busy = '0;
      #1;
      chk("ar_busy", 32'(busy), 32'h00);
      chk("ar_free_count", 32'(free_count), 32'd8);
      chk("ar_empty", 32'(empty), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b00, 1'b1, 8'h01, 1'b0);
      tick();
      chk("redund_busy", 32'(busy), 32'h00);
      chk("redund_free_count", 32'(free_count), 32'd8);
      drive(2'b00, 1'b0, 8'h00, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_priority_allocator.md
# multi_priority_allocator

Parametrised, stateful successor to the single-output priority decoder. It holds a busy bitmap of DEPTH entries and, each cycle, grants up to NUM_ALLOC lowest-index free entries to parallel request slots. It retires entries through a free mask and supports a full flush. It is used as the entry allocator for the ROB, reservation stations and the physical-register free list in the OoO core.

## Interface
- DEPTH, 8: number of tracked entries; must be a power of two, ≥ 2.
- NUM_ALLOC, 2: parallel allocation slots per cycle, 1..DEPTH.
- IDX_W, $clog2(DEPTH): entry index width (derived; do not override).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- alloc_req  in  NUM_ALLOC  per-slot allocation request.
- alloc_gnt  out  NUM_ALLOC  per-slot grant (combinational).
- alloc_idx  out  NUM_ALLOC*IDX_W  granted index; slot k occupies bits [k*IDX_W +: IDX_W].
- free_valid  in  1  qualifies free_mask.
- free_mask  in  DEPTH  entries to release.
- flush  in  1  release all entries.
- busy  out  DEPTH  registered busy bitmap.
- free_count  out  IDX_W+1  registered count of free entries, range 0..DEPTH.
- full  out  1  registered; high when free_count == 0.
- empty  out  1  registered; high when free_count == DEPTH.

## Operation
- Free-entry ranking: from the registered busy bitmap, find the k-th lowest-index free entry F_k for k = 0..NUM_ALLOC-1, using a cascaded priority encode with a mask-out per stage.
- Grant rule:
  - alloc_gnt[k] = alloc_req[k] & F_k exists & !flush.
  - alloc_idx slot k = F_k. Slot k always maps to the k-th free entry, whether or not lower slots request.
  - When there is no grant, alloc_idx slot k still shows F_k if it exists, otherwise 0. The value is don't-care for verification unless alloc_gnt[k] is high.
- Next-state busy:
  - flush: busy_next = 0.
  - otherwise: busy_next = (busy & ~(free_valid ? free_mask : 0)) | granted_onehots.
- Freeing an entry that is not busy has no effect; no error is raised.
- free_count is updated to DEPTH - popcount(busy_next). It must always equal DEPTH - popcount(busy). full and empty are derived from the same next-state value.
- Entries freed in a cycle are not grantable in that same cycle. A grant can only hit an entry that is free in the registered busy, so a grant and a free can never target the same entry in one cycle.
- flush has priority over every other input. It suppresses grants and ignores free_mask in that cycle.

## Timing
- Reset (rst_n low, asynchronous): busy = 0, free_count = DEPTH, full = 0, empty = 1. With busy = 0, alloc_gnt = alloc_req and slot k's alloc_idx = k.
- Deassertion of rst_n is synchronised externally; the block assumes it is clean relative to clk.
- Grant latency is 0 cycles: alloc_gnt and alloc_idx are combinational from alloc_req, flush and registered state.
- The grant takes effect on busy, free_count, full and empty at the next rising edge. Free and flush have the same 1-cycle visibility.
- Requester contract: a requester treats alloc_gnt[k] high at a rising edge as a consumed allocation. There is no hold or retry state; an ungranted request is simply re-presented.
- Boundaries:
  - Fewer than NUM_ALLOC free entries: only the lowest slots whose F_k exists are granted.
  - full: no grants at all.
  - Allocating the last free entry sets full on the next cycle.
  - Freeing every busy entry sets empty on the next cycle.
  - Reset asserted mid-operation clears all state immediately, regardless of clk.

## Test plan
All scenarios use DEPTH=8, NUM_ALLOC=2.
1. **Reset.** Hold rst_n=0, drive alloc_req=2'b11 → busy=0, free_count=8, empty=1, full=0, alloc_gnt=2'b11, idx0=0, idx1=1. Release reset, clock once → busy=8'h03, free_count=6, empty=0.
2. **Fill.** Drive alloc_req=2'b11 for 4 cycles from reset → grants (0,1),(2,3),(4,5),(6,7). Then busy=8'hFF, full=1, free_count=0. A fifth request → alloc_gnt=0 and busy unchanged.
3. **Holes / partial grant.** Set busy=8'hFF, free_mask=8'b0010_0100 → next cycle busy=8'hDB, free_count=2. alloc_req=2'b11 → idx0=2, idx1=5. alloc_req=2'b10 alone → gnt=2'b10, idx1=5, and after the edge busy=8'hFB. Separately, with only entry 2 free, alloc_req=2'b11 → gnt=2'b01, idx0=2.
4. **Simultaneous free+alloc.** Set busy=8'hFE, then in one cycle free_mask=8'h02 and alloc_req=2'b11 → gnt=2'b01, idx0=0. Next cycle busy=8'hFD, free_count=1. Entry 1 is not granted in the freeing cycle.
5. **Flush priority.** Set busy=8'h3C, then in one cycle flush=1, alloc_req=2'b11, free_valid=1 → alloc_gnt=0. Next cycle busy=0, free_count=8, empty=1.
6. **Async reset mid-run.** Set busy=8'hA5, then pull rst_n low between edges → busy=0, free_count=8 immediately, without waiting for a clk edge. A redundant free of an idle entry (free_mask=8'h01 when busy=0) → busy=0, free_count=8.
